// File: rtl/int_issue_queue.sv
// int_issue_queue: age-ordered integer reservation station.
// Collapsing array (entry 0 oldest), CDB operand wakeup, oldest-ready select,
// registered issue outputs into the integer execution unit.
// Optional feature: define INT_IQ_CDB_BYPASS_EN to let select and the issue
// registers use the current-cycle CDB broadcast, saving one cycle of wakeup latency.
module int_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dispatch_valid,
    input  logic [6:0]       dispatch_opcode,
    input  logic [2:0]       dispatch_funct3,
    input  logic [6:0]       dispatch_funct7,
    input  logic [31:0]      dispatch_rs1_data,
    input  logic [TAG_W-1:0] dispatch_rs1_tag,
    input  logic             dispatch_rs1_rdy,
    input  logic [31:0]      dispatch_rs2_data,
    input  logic [TAG_W-1:0] dispatch_rs2_tag,
    input  logic             dispatch_rs2_rdy,
    input  logic [TAG_W-1:0] dispatch_rd_tag,
    output logic             iq_full,
    input  logic [31:0]      cdb_data,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic             cdb_valid,
    input  logic             cdb_branch,
    input  logic             cdb_branch_taken,
    input  logic             flush,
    output logic             issue_int,
    output logic [6:0]       issue_opcode,
    output logic [2:0]       issue_funct3,
    output logic [6:0]       issue_funct7,
    output logic [31:0]      issue_rs1,
    output logic [31:0]      issue_rs2,
    output logic [TAG_W-1:0] issue_rd_tag
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic             valid;
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [31:0]      rs1_data;
        logic [TAG_W-1:0] rs1_tag;
        logic             rs1_rdy;
        logic [31:0]      rs2_data;
        logic [TAG_W-1:0] rs2_tag;
        logic             rs2_rdy;
        logic [TAG_W-1:0] rd_tag;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    // One spare all-invalid slot so the collapse shift never indexes past the array.
    entry_t           woke  [DEPTH+1];
    entry_t           disp_e;
    logic [CNT_W-1:0] count_q, count_d;
    logic             iq_full_q, iq_full_d;
    logic [DEPTH-1:0] sel_rdy;
    logic             issue_fire;
    logic [IDX_W-1:0] sel_idx;
    logic             do_issue;
    logic             accept;
    logic [CNT_W-1:0] wr_idx;

    logic             issue_int_q, issue_int_d;
    logic [6:0]       issue_opcode_q, issue_opcode_d;
    logic [2:0]       issue_funct3_q, issue_funct3_d;
    logic [6:0]       issue_funct7_q, issue_funct7_d;
    logic [31:0]      issue_rs1_q, issue_rs1_d;
    logic [31:0]      issue_rs2_q, issue_rs2_d;
    logic [TAG_W-1:0] issue_rd_tag_q, issue_rd_tag_d;

    // Branch resolution fields of the CDB are not needed by this queue.
    logic unused_cdb_branch;
    assign unused_cdb_branch = cdb_branch ^ cdb_branch_taken;

    // Per-entry CDB wakeup and ready-to-select flags.
    always_comb begin
        woke[DEPTH] = '0;
        sel_rdy     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            woke[i] = ent_q[i];
            if (ent_q[i].valid && !ent_q[i].rs1_rdy && cdb_valid && cdb_tag == ent_q[i].rs1_tag) begin
                woke[i].rs1_data = cdb_data;
                woke[i].rs1_rdy  = 1'b1;
            end
            if (ent_q[i].valid && !ent_q[i].rs2_rdy && cdb_valid && cdb_tag == ent_q[i].rs2_tag) begin
                woke[i].rs2_data = cdb_data;
                woke[i].rs2_rdy  = 1'b1;
            end
`ifdef INT_IQ_CDB_BYPASS_EN
            sel_rdy[i] = woke[i].valid && woke[i].rs1_rdy && woke[i].rs2_rdy;
`else
            sel_rdy[i] = ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
`endif
        end
    end

    // Oldest-ready select: scan from the top so the lowest ready index wins.
    always_comb begin
        issue_fire = 1'b0;
        sel_idx    = '0;
        for (int unsigned i = DEPTH; i > 0; i--) begin
            if (sel_rdy[i-1]) begin
                issue_fire = 1'b1;
                sel_idx    = IDX_W'(i - 1);
            end
        end
    end

    // Build the incoming entry, capturing a matching same-cycle CDB broadcast.
    always_comb begin
        disp_e          = '0;
        disp_e.valid    = 1'b1;
        disp_e.opcode   = dispatch_opcode;
        disp_e.funct3   = dispatch_funct3;
        disp_e.funct7   = dispatch_funct7;
        disp_e.rs1_data = dispatch_rs1_data;
        disp_e.rs1_tag  = dispatch_rs1_tag;
        disp_e.rs1_rdy  = dispatch_rs1_rdy;
        disp_e.rs2_data = dispatch_rs2_data;
        disp_e.rs2_tag  = dispatch_rs2_tag;
        disp_e.rs2_rdy  = dispatch_rs2_rdy;
        disp_e.rd_tag   = dispatch_rd_tag;
        if (!dispatch_rs1_rdy && cdb_valid && cdb_tag == dispatch_rs1_tag) begin
            disp_e.rs1_data = cdb_data;
            disp_e.rs1_rdy  = 1'b1;
        end
        if (!dispatch_rs2_rdy && cdb_valid && cdb_tag == dispatch_rs2_tag) begin
            disp_e.rs2_data = cdb_data;
            disp_e.rs2_rdy  = 1'b1;
        end
    end

    // Next state: collapse past the issued slot, append dispatch, update issue registers.
    always_comb begin
        do_issue = issue_fire && !flush;
        accept   = dispatch_valid && !iq_full_q && !flush;
        wr_idx   = do_issue ? (count_q - CNT_W'(1)) : count_q;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (do_issue && i >= 32'(sel_idx)) begin
                ent_d[i] = woke[i+1];
            end else begin
                ent_d[i] = woke[i];
            end
            if (accept && CNT_W'(i) == wr_idx) begin
                ent_d[i] = disp_e;
            end
        end

        count_d = count_q;
        if (do_issue) begin
            count_d = count_d - CNT_W'(1);
        end
        if (accept) begin
            count_d = count_d + CNT_W'(1);
        end

        issue_int_d    = 1'b0;
        issue_opcode_d = issue_opcode_q;
        issue_funct3_d = issue_funct3_q;
        issue_funct7_d = issue_funct7_q;
        issue_rs1_d    = issue_rs1_q;
        issue_rs2_d    = issue_rs2_q;
        issue_rd_tag_d = issue_rd_tag_q;
        if (do_issue) begin
            issue_int_d    = 1'b1;
            issue_opcode_d = woke[sel_idx].opcode;
            issue_funct3_d = woke[sel_idx].funct3;
            issue_funct7_d = woke[sel_idx].funct7;
            issue_rs1_d    = woke[sel_idx].rs1_data;
            issue_rs2_d    = woke[sel_idx].rs2_data;
            issue_rd_tag_d = woke[sel_idx].rd_tag;
        end

        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_d[i] = '0;
            end
            count_d = '0;
        end

        iq_full_d = (count_d == CNT_W'(DEPTH));
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            count_q        <= '0;
            iq_full_q      <= 1'b0;
            issue_int_q    <= 1'b0;
            issue_opcode_q <= '0;
            issue_funct3_q <= '0;
            issue_funct7_q <= '0;
            issue_rs1_q    <= '0;
            issue_rs2_q    <= '0;
            issue_rd_tag_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q        <= count_d;
            iq_full_q      <= iq_full_d;
            issue_int_q    <= issue_int_d;
            issue_opcode_q <= issue_opcode_d;
            issue_funct3_q <= issue_funct3_d;
            issue_funct7_q <= issue_funct7_d;
            issue_rs1_q    <= issue_rs1_d;
            issue_rs2_q    <= issue_rs2_d;
            issue_rd_tag_q <= issue_rd_tag_d;
        end
    end

    assign iq_full      = iq_full_q;
    assign issue_int    = issue_int_q;
    assign issue_opcode = issue_opcode_q;
    assign issue_funct3 = issue_funct3_q;
    assign issue_funct7 = issue_funct7_q;
    assign issue_rs1    = issue_rs1_q;
    assign issue_rs2    = issue_rs2_q;
    assign issue_rd_tag = issue_rd_tag_q;

endmodule

// File: tb/tb_int_issue_queue.sv
// Scoreboard bench for int_issue_queue: stimulus pushes expected issues
// (including the cycle they must appear in); a negedge monitor pops and compares.
module tb_int_issue_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 6;
`ifdef INT_IQ_CDB_BYPASS_EN
    localparam int WAKE_LAT = 1;
`else
    localparam int WAKE_LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             dispatch_valid = 1'b0;
    logic [6:0]       dispatch_opcode = '0;
    logic [2:0]       dispatch_funct3 = '0;
    logic [6:0]       dispatch_funct7 = '0;
    logic [31:0]      dispatch_rs1_data = '0;
    logic [TAG_W-1:0] dispatch_rs1_tag = '0;
    logic             dispatch_rs1_rdy = 1'b0;
    logic [31:0]      dispatch_rs2_data = '0;
    logic [TAG_W-1:0] dispatch_rs2_tag = '0;
    logic             dispatch_rs2_rdy = 1'b0;
    logic [TAG_W-1:0] dispatch_rd_tag = '0;
    logic             iq_full;
    logic [31:0]      cdb_data = '0;
    logic [TAG_W-1:0] cdb_tag = '0;
    logic             cdb_valid = 1'b0;
    logic             cdb_branch = 1'b0;
    logic             cdb_branch_taken = 1'b0;
    logic             flush = 1'b0;
    logic             issue_int;
    logic [6:0]       issue_opcode;
    logic [2:0]       issue_funct3;
    logic [6:0]       issue_funct7;
    logic [31:0]      issue_rs1;
    logic [31:0]      issue_rs2;
    logic [TAG_W-1:0] issue_rd_tag;

    int checks = 0;
    int failures = 0;
    int n_issued = 0;
    int n_expected = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [5:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    int_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .dispatch_valid    (dispatch_valid),
        .dispatch_opcode   (dispatch_opcode),
        .dispatch_funct3   (dispatch_funct3),
        .dispatch_funct7   (dispatch_funct7),
        .dispatch_rs1_data (dispatch_rs1_data),
        .dispatch_rs1_tag  (dispatch_rs1_tag),
        .dispatch_rs1_rdy  (dispatch_rs1_rdy),
        .dispatch_rs2_data (dispatch_rs2_data),
        .dispatch_rs2_tag  (dispatch_rs2_tag),
        .dispatch_rs2_rdy  (dispatch_rs2_rdy),
        .dispatch_rd_tag   (dispatch_rd_tag),
        .iq_full           (iq_full),
        .cdb_data          (cdb_data),
        .cdb_tag           (cdb_tag),
        .cdb_valid         (cdb_valid),
        .cdb_branch        (cdb_branch),
        .cdb_branch_taken  (cdb_branch_taken),
        .flush             (flush),
        .issue_int         (issue_int),
        .issue_opcode      (issue_opcode),
        .issue_funct3      (issue_funct3),
        .issue_funct7      (issue_funct7),
        .issue_rs1         (issue_rs1),
        .issue_rs2         (issue_rs2),
        .issue_rd_tag      (issue_rd_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every issue pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && issue_int) begin
            n_issued++;
            if (exp_q.size() == 0) begin
                check("unexpected_issue", {58'd0, issue_rd_tag}, 64'hFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("issue_cycle",  64'(cyc), 64'(mon_e.cyc));
                check("issue_opcode", 64'(issue_opcode), 64'(mon_e.op));
                check("issue_funct3", 64'(issue_funct3), 64'(mon_e.f3));
                check("issue_funct7", 64'(issue_funct7), 64'(mon_e.f7));
                check("issue_rs1",    64'(issue_rs1), 64'(mon_e.rs1));
                check("issue_rs2",    64'(issue_rs2), 64'(mon_e.rs2));
                check("issue_rd_tag", 64'(issue_rd_tag), 64'(mon_e.rd));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic expect_at(input int c, input logic [6:0] op, input logic [31:0] r1,
                             input logic [31:0] r2, input logic [5:0] rd);
        exp_t e;
        e.cyc = c;
        e.op  = op;
        e.f3  = rd[2:0];
        e.f7  = {1'b0, rd};
        e.rs1 = r1;
        e.rs2 = r2;
        e.rd  = rd;
        exp_q.push_back(e);
        n_expected++;
    endtask

    // One-cycle dispatch request; funct3/funct7 are derived from rd so each issue is distinct.
    task automatic disp(input logic [6:0] op,
                        input logic [31:0] d1, input logic [5:0] t1, input logic r1,
                        input logic [31:0] d2, input logic [5:0] t2, input logic r2,
                        input logic [5:0] rd);
        dispatch_valid    = 1'b1;
        dispatch_opcode   = op;
        dispatch_funct3   = rd[2:0];
        dispatch_funct7   = {1'b0, rd};
        dispatch_rs1_data = d1;
        dispatch_rs1_tag  = t1;
        dispatch_rs1_rdy  = r1;
        dispatch_rs2_data = d2;
        dispatch_rs2_tag  = t2;
        dispatch_rs2_rdy  = r2;
        dispatch_rd_tag   = rd;
        step();
        dispatch_valid    = 1'b0;
    endtask

    task automatic cdb_pulse(input logic [5:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
        step();
        cdb_valid = 1'b0;
        cdb_tag   = '0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int c;

        // Reset held two cycles.
        step();
        step();
        check("rst_issue_int", 64'(issue_int), 64'd0);
        check("rst_iq_full",   64'(iq_full), 64'd0);
        check("rst_issue_rs1", 64'(issue_rs1), 64'd0);
        check("rst_issue_rs2", 64'(issue_rs2), 64'd0);
        check("rst_rd_tag",    64'(issue_rd_tag), 64'd0);
        check("rst_opcode",    64'(issue_opcode), 64'd0);
        rst = 1'b0;
        idle(2);

        // Ready dispatch: issues two cycles after the dispatch cycle, single pulse.
        k = cyc;
        expect_at(k + 2, OP_ALU, 32'd5, 32'd7, 6'd3);
        disp(OP_ALU, 32'd5, 6'd0, 1'b1, 32'd7, 6'd0, 1'b1, 6'd3);
        wait_drain("drain_ready", 10);
        idle(3);

        // CDB wakeup of rs1.
        k = cyc;
        disp(OP_ALU, 32'hDEAD, 6'd9, 1'b0, 32'd1, 6'd0, 1'b1, 6'd10);
        idle(1);
        c = cyc;
        expect_at(c + WAKE_LAT, OP_ALU, 32'h20, 32'd1, 6'd10);
        cdb_pulse(6'd9, 32'h20);
        wait_drain("drain_wakeup", 10);
        idle(2);

        // Dispatch-time capture from a same-cycle broadcast.
        k = cyc;
        cdb_valid = 1'b1;
        cdb_tag   = 6'd5;
        cdb_data  = 32'h55;
        expect_at(k + 2, OP_BR, 32'h55, 32'h66, 6'd11);
        disp(OP_BR, 32'hBAD, 6'd5, 1'b0, 32'h66, 6'd0, 1'b1, 6'd11);
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        wait_drain("drain_capture", 10);
        idle(2);

        // Tag 0 without cdb_valid must not wake; a valid tag-0 broadcast does.
        disp(OP_ALU, 32'd3, 6'd0, 1'b1, 32'hBAD, 6'd0, 1'b0, 6'd12);
        cdb_data = 32'h99;
        idle(3);
        c = cyc;
        expect_at(c + WAKE_LAT, OP_ALU, 32'd3, 32'h77, 6'd12);
        cdb_pulse(6'd0, 32'h77);
        wait_drain("drain_tag0", 10);
        idle(2);

        // Age order and full: four waiting entries fill the queue, a fifth is dropped.
        k = cyc;
        for (int j = 0; j < 4; j++) begin
            disp(OP_ALU, 32'd0, 6'd12, 1'b0, 32'(16 * (j + 1)), 6'd0, 1'b1, 6'(j + 1));
        end
        check("full_after_4", 64'(iq_full), 64'd1);
        disp(OP_ALU, 32'd1, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 6'd5);
        check("full_after_drop", 64'(iq_full), 64'd1);
        c = cyc;
        for (int j = 0; j < 4; j++) begin
            expect_at(c + WAKE_LAT + j, OP_ALU, 32'hC, 32'(16 * (j + 1)), 6'(j + 1));
        end
        cdb_pulse(6'd12, 32'hC);
        for (int j = 0; j < 4; j++) begin
            check("full_falls", 64'(iq_full), (cyc < c + WAKE_LAT) ? 64'd1 : 64'd0);
            step();
        end
        wait_drain("drain_full", 10);
        idle(2);

        // Out-of-order issue: younger ready entry goes first.
        k = cyc;
        disp(OP_ALU, 32'hBAD, 6'd8, 1'b0, 32'd2, 6'd0, 1'b1, 6'd20);
        expect_at(k + 3, OP_BR, 32'h11, 32'h22, 6'd21);
        disp(OP_BR, 32'h11, 6'd0, 1'b1, 32'h22, 6'd0, 1'b1, 6'd21);
        idle(2);
        c = cyc;
        expect_at(c + WAKE_LAT, OP_ALU, 32'h88, 32'd2, 6'd20);
        cdb_pulse(6'd8, 32'h88);
        wait_drain("drain_ooo", 10);
        idle(2);

        // Flush with three entries (one about to issue) and a same-cycle dispatch.
        disp(OP_ALU, 32'd0, 6'd30, 1'b0, 32'd1, 6'd0, 1'b1, 6'd30);
        disp(OP_ALU, 32'd0, 6'd31, 1'b0, 32'd1, 6'd0, 1'b1, 6'd31);
        disp(OP_ALU, 32'd4, 6'd0, 1'b1, 32'd4, 6'd0, 1'b1, 6'd33);
        flush = 1'b1;
        disp(OP_ALU, 32'd9, 6'd0, 1'b1, 32'd9, 6'd0, 1'b1, 6'd40);
        flush = 1'b0;
        check("flush_issue_int", 64'(issue_int), 64'd0);
        check("flush_iq_full",   64'(iq_full), 64'd0);
        cdb_pulse(6'd30, 32'h1);
        cdb_pulse(6'd31, 32'h2);
        idle(4);

        // Queue still works after flush.
        k = cyc;
        expect_at(k + 2, OP_BR, 32'hA5A5A5A5, 32'h5A5A5A5A, 6'd50);
        disp(OP_BR, 32'hA5A5A5A5, 6'd0, 1'b1, 32'h5A5A5A5A, 6'd0, 1'b1, 6'd50);
        wait_drain("drain_post_flush", 10);
        idle(4);

        check("issue_count", 64'(n_issued), 64'(n_expected));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
